// File: rtl/mem_arbiter_if.sv
// Bus bundle between the pipeline (IF / MEM stages), the memory arbiter
// and the single-port RAM. The arbiter sits on the slave side; the
// pipeline plus RAM model sit on the master side.
interface mem_arbiter_if #(
  parameter int WIDTH = 32
);
  // Fetch port
  logic             if_req;
  logic [WIDTH-1:0] if_addr;
  logic [WIDTH-1:0] if_rdata;
  logic             if_ready;
  // Data port
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ready;
  // RAM port
  logic             ram_en;
  logic             ram_we;
  logic [WIDTH-1:0] ram_addr;
  logic [WIDTH-1:0] ram_wdata;
  logic [WIDTH-1:0] ram_rdata;
  logic             ram_ack;
  // Pipeline control
  logic             pc_write;
  logic             ifid_write;
  logic             exmem_stall;
  logic             err;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
           ram_rdata, ram_ack,
    output if_rdata, if_ready, mem_rdata, mem_ready,
           ram_en, ram_we, ram_addr, ram_wdata,
           pc_write, ifid_write, exmem_stall, err
  );

  // Pipeline / RAM side
  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
           ram_rdata, ram_ack,
    input  if_rdata, if_ready, mem_rdata, mem_ready,
           ram_en, ram_we, ram_addr, ram_wdata,
           pc_write, ifid_write, exmem_stall, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port RAM between the instruction fetch port
// and the MEM-stage data port. One access at a time: IDLE arbitrates,
// BUSY holds the RAM strobe until ram_ack (or a timeout), DONE pulses the
// granted port's ready for exactly one cycle. On simultaneous requests the
// data port wins unless it won last time, so fetch is never starved.
module mem_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15   // 1..255 BUSY cycles without ack before giving up
) (
  input  logic         clk,
  input  logic         rst,    // synchronous, active low
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic       GNT_IF   = 1'b0;
  localparam logic       GNT_MEM  = 1'b1;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic             gnt_q, gnt_d;           // current owner of the RAM
  logic             lg_q, lg_d;             // owner of the previous access
  logic             ram_en_q, ram_en_d;
  logic             ram_we_q, ram_we_d;
  logic [WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic [WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [WIDTH-1:0] mem_rdata_q, mem_rdata_d;
  logic [7:0]       cnt_q, cnt_d;           // BUSY cycles seen without ack
  logic             err_q, err_d;
  logic             sel_mem;                // arbitration result in IDLE
  logic             if_ready_w, mem_ready_w;

  // Next-state and datapath updates; everything holds unless a case changes it
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    lg_d        = lg_q;
    ram_en_d    = ram_en_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    // Data wins a tie unless it also won the previous access
    sel_mem     = bus.mem_req & ~(bus.if_req & lg_q);

    case (state_q)
      IDLE: begin
        if (bus.if_req | bus.mem_req) begin
          state_d     = BUSY;
          gnt_d       = sel_mem;
          lg_d        = sel_mem;
          ram_en_d    = 1'b1;
          ram_we_d    = sel_mem & bus.mem_we;
          ram_addr_d  = sel_mem ? bus.mem_addr : bus.if_addr;
          ram_wdata_d = sel_mem ? bus.mem_wdata : '0;
          cnt_d       = '0;
        end
      end

      BUSY: begin
        if (bus.ram_ack) begin
          // A store returns no data, so its load-data register reads zero
          if (gnt_q == GNT_MEM) begin
            mem_rdata_d = ram_we_q ? '0 : bus.ram_rdata;
          end else begin
            if_rdata_d = bus.ram_rdata;
          end
          ram_en_d = 1'b0;
          ram_we_d = 1'b0;
          state_d  = DONE;
        end else if (cnt_q == CNT_LAST) begin
          // Give up: release the RAM and complete with zero data
          if (gnt_q == GNT_MEM) begin
            mem_rdata_d = '0;
          end else begin
            if_rdata_d = '0;
          end
          ram_en_d = 1'b0;
          ram_we_d = 1'b0;
          err_d    = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_IF;
      lg_q        <= GNT_MEM;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      lg_q        <= lg_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  // Ready pulses are decoded purely from registered state, so they are
  // glitch-free and last exactly the one DONE cycle
  assign if_ready_w  = (state_q == DONE) && (gnt_q == GNT_IF);
  assign mem_ready_w = (state_q == DONE) && (gnt_q == GNT_MEM);

  assign bus.if_ready  = if_ready_w;
  assign bus.mem_ready = mem_ready_w;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.err       = err_q;

  // Pipeline hold: any stage with an outstanding request freezes the front end
  assign bus.pc_write    = ~((bus.if_req & ~if_ready_w) | (bus.mem_req & ~mem_ready_w));
  assign bus.ifid_write  = bus.pc_write;
  assign bus.exmem_stall = bus.mem_req & ~mem_ready_w;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.WIDTH(WIDTH)) bus ();
  mem_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int txn_no = 0;

  // Reference model state
  bit          lg_m;            // 1 = data port owned the previous access
  bit          err_m;
  logic [31:0] exp_if_rdata, exp_mem_rdata;
  // Requests presented by the pipeline
  bit          if_pend, mem_pend, we_pend;
  logic [31:0] if_a, mem_a, mem_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_inputs();
    bus.if_req    = if_pend;
    bus.if_addr   = if_a;
    bus.mem_req   = mem_pend;
    bus.mem_we    = we_pend;
    bus.mem_addr  = mem_a;
    bus.mem_wdata = mem_d;
  endtask

  task automatic new_fetch();
    if_pend = 1'b1;
    if_a    = $urandom;
  endtask

  task automatic new_data();
    mem_pend = 1'b1;
    we_pend  = 1'($urandom_range(0, 1));
    mem_a    = $urandom;
    mem_d    = $urandom;
  endtask

  // One complete access, entered and left in IDLE (1 time unit after an edge).
  // lat = BUSY cycles before ram_ack is driven; negative or >= TIMEOUT means never.
  task automatic txn(input int lat, input logic [31:0] rd, input bit drop_mid,
                     input bit renew, output bit g);
    bit tmo;
    int n;
    logic [31:0] addr_x;
    bit we_x;
    if (if_pend && mem_pend) g = lg_m ? 1'b0 : 1'b1;
    else                     g = mem_pend;
    lg_m   = g;
    tmo    = (lat < 0) || (lat >= TIMEOUT);
    n      = tmo ? TIMEOUT : lat + 1;
    addr_x = g ? mem_a : if_a;
    we_x   = g && we_pend;

    apply_inputs();
    #1;
    check("idle_ram_en", bus.ram_en, 0);
    check("idle_pc_write", bus.pc_write, !(if_pend || mem_pend));
    check("idle_exmem_stall", bus.exmem_stall, mem_pend);
    @(posedge clk); #1;

    for (int k = 0; k < n; k++) begin
      check("busy_ram_en", bus.ram_en, 1);
      check("busy_ram_addr", bus.ram_addr, addr_x);
      check("busy_ram_we", bus.ram_we, we_x);
      if (g) check("busy_ram_wdata", bus.ram_wdata, mem_d);
      check("busy_pc_write", bus.pc_write, !(bus.if_req || bus.mem_req));
      check("busy_ifid_write", bus.ifid_write, !(bus.if_req || bus.mem_req));
      check("busy_exmem_stall", bus.exmem_stall, bus.mem_req);
      check("busy_ready", {bus.if_ready, bus.mem_ready}, 0);
      if (k == 0 && drop_mid) begin
        if (g) begin mem_pend = 1'b0; bus.mem_req = 1'b0; end
        else   begin if_pend  = 1'b0; bus.if_req  = 1'b0; end
      end
      bus.ram_ack   = !tmo && (k == lat);
      bus.ram_rdata = (k == lat) ? rd : 32'($urandom);
      @(posedge clk); #1;
    end
    bus.ram_ack = 1'b0;

    // DONE cycle
    if (g) exp_mem_rdata = (tmo || we_pend) ? 32'h0 : rd;
    else   exp_if_rdata  = tmo ? 32'h0 : rd;
    if (tmo) err_m = 1'b1;
    check("done_ram_en", bus.ram_en, 0);
    check("done_ram_we", bus.ram_we, 0);
    check("done_if_ready", bus.if_ready, !g);
    check("done_mem_ready", bus.mem_ready, g);
    check("done_if_rdata", bus.if_rdata, exp_if_rdata);
    check("done_mem_rdata", bus.mem_rdata, exp_mem_rdata);
    check("done_err", bus.err, err_m);
    check("done_pc_write", bus.pc_write, !((bus.if_req && g) || (bus.mem_req && !g)));
    check("done_exmem_stall", bus.exmem_stall, bus.mem_req && !g);
    $display("txn %0d: grant=%s we=%0d addr=%h lat=%0d timeout=%0d rdata_if=%h rdata_mem=%h err=%0d",
             txn_no, g ? "data " : "fetch", we_x, addr_x, lat, tmo,
             bus.if_rdata, bus.mem_rdata, bus.err);
    txn_no++;

    // Retire the granted request, optionally replacing it with a new one
    if (g) begin
      if (renew) new_data(); else mem_pend = 1'b0;
    end else begin
      if (renew) new_fetch(); else if_pend = 1'b0;
    end
    apply_inputs();
    @(posedge clk); #1;
    check("after_done_ready", {bus.if_ready, bus.mem_ready}, 0);
    check("after_done_ram_en", bus.ram_en, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ram_en"}, bus.ram_en, 0);
    check({tag, "_ram_we"}, bus.ram_we, 0);
    check({tag, "_ram_addr"}, bus.ram_addr, 0);
    check({tag, "_ram_wdata"}, bus.ram_wdata, 0);
    check({tag, "_if_rdata"}, bus.if_rdata, 0);
    check({tag, "_mem_rdata"}, bus.mem_rdata, 0);
    check({tag, "_ready"}, {bus.if_ready, bus.mem_ready}, 0);
    check({tag, "_err"}, bus.err, 0);
  endtask

  // Safety net against a hung simulation
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit g;
    int r, lat;
    if_pend = 0; mem_pend = 0; we_pend = 0;
    if_a = 0; mem_a = 0; mem_d = 0;
    apply_inputs();
    bus.ram_ack = 1'b0;
    bus.ram_rdata = '0;
    lg_m = 1'b1; err_m = 1'b0;
    exp_if_rdata = '0; exp_mem_rdata = '0;

    // Reset values
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b1;

    // Contention straight after reset: fetch, data, fetch, data
    new_fetch();
    new_data();
    for (int k = 0; k < 4; k++) begin
      txn(1, $urandom, 1'b0, (k < 3), g);
      check("contention_order", g, (k % 2));
    end
    txn(0, $urandom, 1'b0, 1'b0, g);     // drain the leftover fetch
    check("contention_drain", g, 0);

    // Plain fetch from 0x40, ack one cycle after ram_en
    if_pend = 1'b1; if_a = 32'h0000_0040;
    txn(1, 32'h2108_0001, 1'b0, 1'b0, g);
    check("fetch_grant", g, 0);
    check("fetch_rdata_held", bus.if_rdata, 32'h2108_0001);

    // Store to 0x100, ack after 3 cycles
    mem_pend = 1'b1; we_pend = 1'b1; mem_a = 32'h0000_0100; mem_d = 32'hDEAD_BEEF;
    txn(3, $urandom, 1'b0, 1'b0, g);
    check("store_grant", g, 1);
    check("store_mem_rdata", bus.mem_rdata, 0);

    // Stray ack in IDLE with no requests
    bus.ram_ack = 1'b1; bus.ram_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    bus.ram_ack = 1'b0;
    check("stray_ram_en", bus.ram_en, 0);
    check("stray_ready", {bus.if_ready, bus.mem_ready}, 0);
    check("stray_if_rdata", bus.if_rdata, exp_if_rdata);
    check("stray_mem_rdata", bus.mem_rdata, exp_mem_rdata);
    @(posedge clk); #1;
    check("stray_ready_later", {bus.if_ready, bus.mem_ready}, 0);

    // Fetch that never gets an ack
    if_pend = 1'b1; if_a = 32'h0000_0200;
    txn(-1, $urandom, 1'b0, 1'b0, g);
    check("timeout_err", bus.err, 1);

    // Ack on the very last BUSY cycle still counts as a normal completion
    mem_pend = 1'b1; we_pend = 1'b0; mem_a = 32'h0000_0300; mem_d = 32'h0;
    txn(TIMEOUT - 1, 32'h1234_5678, 1'b0, 1'b0, g);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      if (!if_pend && !mem_pend) begin
        r = $urandom_range(1, 3);
        if (r[0]) new_fetch();
        if (r[1]) new_data();
      end
      r = $urandom_range(0, 11);
      lat = (r == 11) ? -1 : (r % 5);
      txn(lat, $urandom, ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), g);
    end
    if_pend = 1'b0; mem_pend = 1'b0;
    apply_inputs();

    // Reset in the middle of a data load, then a late ack
    mem_pend = 1'b1; we_pend = 1'b0; mem_a = 32'h0000_0400; mem_d = 32'h0;
    apply_inputs();
    @(posedge clk); #1;
    check("midreset_busy", bus.ram_en, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    mem_pend = 1'b0;
    apply_inputs();
    bus.ram_ack = 1'b1; bus.ram_rdata = 32'hCAFE_F00D;
    lg_m = 1'b1; err_m = 1'b0; exp_if_rdata = '0; exp_mem_rdata = '0;
    check_reset_values("midreset");
    @(posedge clk); #1;
    bus.ram_ack = 1'b0;
    check_reset_values("midreset_ack");
    $display("txn %0d: reset during data access, late ack ignored", txn_no);
    txn_no++;

    // First simultaneous request after reset goes to fetch
    new_fetch();
    new_data();
    txn(2, $urandom, 1'b0, 1'b0, g);
    check("post_reset_first_grant", g, 0);
    txn(2, $urandom, 1'b0, 1'b0, g);
    check("post_reset_second_grant", g, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
